// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one memory port between the instruction fetch unit (read-only) and
// the load/store unit (read/write). One transaction is in flight at a time.
// The response is routed back to whichever requester issued the request.
// The LSU normally wins arbitration. The IFU is forced through after
// STARVE_LIMIT consecutive LSU grants that it sat through. If memory stays
// silent for TIMEOUT wait cycles, an error response is returned to the owner.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   ifu_req_*           IFU read request (valid/ready, raddr)
//   ifu_resp_*          IFU response strobe, read data, timeout error flag
//   lsu_req_*           LSU request (valid/ready, wen, addr, wdata, wmask)
//   lsu_resp_*          LSU response strobe, read data, timeout error flag
//   mem_req_*           request to memory (valid/ready, wen, addr, wdata, wmask)
//   mem_resp_valid      memory response strobe
//   mem_rdata           memory read data
module mem_port_arbiter #(
  parameter int TIMEOUT      = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_raddr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IFU = 2'd1,
    WAIT_LSU = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;

  logic starve_at_limit;
  logic lsu_win;
  logic ifu_win;
  logic timeout_hit;
  logic resp_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    starve_cnt_next = starve_cnt_reg;

    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    ifu_resp_err   = 1'b0;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    lsu_resp_err   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_wen        = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wmask      = '0;

    starve_at_limit = (starve_cnt_reg == SW'(STARVE_LIMIT));
    // The IFU only overrides the LSU once it has been passed over enough times.
    lsu_win     = lsu_req_valid && !(ifu_req_valid && starve_at_limit);
    ifu_win     = !lsu_win && ifu_req_valid;
    timeout_hit = (timer_reg == TW'(TIMEOUT - 1));
    // A real response on the timeout cycle takes precedence over the error.
    resp_fire   = mem_resp_valid || timeout_hit;

    // All strobes are gated off while reset is held.
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          if (lsu_win) begin
            mem_req_valid = 1'b1;
            mem_wen       = lsu_wen;
            mem_addr      = lsu_addr;
            mem_wdata     = lsu_wdata;
            mem_wmask     = lsu_wmask;
            lsu_req_ready = mem_req_ready;
            if (mem_req_ready) begin
              state_next = WAIT_LSU;
              timer_next = '0;
              // Count only LSU grants the IFU actually waited through.
              if (!ifu_req_valid) begin
                starve_cnt_next = '0;
              end else if (!starve_at_limit) begin
                starve_cnt_next = starve_cnt_reg + SW'(1);
              end
            end
          end else if (ifu_win) begin
            mem_req_valid = 1'b1;
            mem_addr      = ifu_raddr;
            ifu_req_ready = mem_req_ready;
            if (mem_req_ready) begin
              state_next      = WAIT_IFU;
              timer_next      = '0;
              starve_cnt_next = '0;
            end
          end
        end

        WAIT_IFU: begin
          if (resp_fire) begin
            ifu_resp_valid = 1'b1;
            ifu_resp_err   = !mem_resp_valid;
            ifu_rdata      = mem_resp_valid ? mem_rdata : 32'd0;
            state_next     = IDLE;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end

        WAIT_LSU: begin
          if (resp_fire) begin
            lsu_resp_valid = 1'b1;
            lsu_resp_err   = !mem_resp_valid;
            lsu_rdata      = mem_resp_valid ? mem_rdata : 32'd0;
            state_next     = IDLE;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by a random
// phase, all checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 8;
  localparam int LIMIT   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_raddr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_raddr(ifu_raddr), .ifu_resp_valid(ifu_resp_valid),
    .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
    .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port (0 none, 1 IFU, 2 LSU), how many
  // wait cycles have elapsed, and how many LSU grants the IFU has sat through.
  int m_owner   = 0;
  int m_elapsed = 0;
  int m_streak  = 0;

  // Bench-side memory and bookkeeping.
  int          resp_cd = -1;
  int          resp_delay = 2;
  logic [31:0] resp_data = '0;
  logic [31:0] fixed_resp_data = '0;
  bit          rand_mode = 1'b0;
  int          cyc = 0;
  int          hs_cyc = 0;
  logic [31:0] grant_bits = '0;
  int          grant_n = 0;
  int          ifu_seen = 0, lsu_seen = 0;
  logic [31:0] last_ifu_rdata = '0, last_lsu_rdata = '0;
  logic        last_ifu_err = 1'b0, last_lsu_err = 1'b0;
  int          last_lsu_cyc = 0;
  int          i0, l0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory side, predict, compare, advance model.
  task automatic cycle();
    logic        e_ir, e_lr, e_mv, e_mw, e_iv, e_ie, e_lv, e_le;
    logic [31:0] e_ma, e_md, e_id, e_ld;
    logic [7:0]  e_mm;
    bit          lsu_pick, ifu_pick, hs_i, hs_l, done;
    int          n_owner, n_elapsed, n_streak, d;

    if (resp_cd == 0) begin
      mem_resp_valid = 1'b1;
      mem_rdata      = resp_data;
      resp_cd        = -1;
    end else begin
      mem_resp_valid = rand_mode && ($urandom_range(0, 24) == 0);
      mem_rdata      = $urandom;
      if (resp_cd > 0) resp_cd--;
    end
    if (rand_mode) begin
      mem_req_ready = ($urandom_range(0, 3) != 0);
      reset         = ($urandom_range(0, 199) == 0);
    end
    #2;

    e_ir = 0; e_lr = 0; e_mv = 0; e_mw = 0; e_ma = 0; e_md = 0; e_mm = 0;
    e_iv = 0; e_ie = 0; e_id = 0; e_lv = 0; e_le = 0; e_ld = 0;
    hs_i = 0; hs_l = 0; lsu_pick = 0; ifu_pick = 0; done = 0;
    n_owner = m_owner; n_elapsed = m_elapsed; n_streak = m_streak;

    if (reset) begin
      n_owner = 0; n_elapsed = 0; n_streak = 0;
    end else if (m_owner == 0) begin
      lsu_pick = lsu_req_valid && !(ifu_req_valid && m_streak >= LIMIT);
      ifu_pick = !lsu_pick && ifu_req_valid;
      if (lsu_pick) begin
        e_mv = 1; e_mw = lsu_wen; e_ma = lsu_addr; e_md = lsu_wdata;
        e_mm = lsu_wmask; e_lr = mem_req_ready;
      end else if (ifu_pick) begin
        e_mv = 1; e_ma = ifu_raddr; e_ir = mem_req_ready;
      end
      hs_l = lsu_pick && mem_req_ready;
      hs_i = ifu_pick && mem_req_ready;
      if (hs_l) begin
        n_owner = 2; n_elapsed = 0;
        n_streak = ifu_req_valid ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
      end
      if (hs_i) begin
        n_owner = 1; n_elapsed = 0; n_streak = 0;
      end
    end else begin
      done = mem_resp_valid || (m_elapsed == TIMEOUT - 1);
      if (done) begin
        if (m_owner == 1) begin
          e_iv = 1; e_ie = !mem_resp_valid; e_id = mem_resp_valid ? mem_rdata : 32'd0;
        end else begin
          e_lv = 1; e_le = !mem_resp_valid; e_ld = mem_resp_valid ? mem_rdata : 32'd0;
        end
        n_owner = 0;
      end
      n_elapsed = m_elapsed + 1;
    end

    chk("ifu_req_ready", ifu_req_ready, e_ir);
    chk("lsu_req_ready", lsu_req_ready, e_lr);
    chk("mem_req", {mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask},
        {e_mv, e_mw, e_ma, e_md, e_mm});
    chk("ifu_resp", {ifu_resp_valid, ifu_resp_err, ifu_rdata}, {e_iv, e_ie, e_id});
    chk("lsu_resp", {lsu_resp_valid, lsu_resp_err, lsu_rdata}, {e_lv, e_le, e_ld});

    if (ifu_resp_valid) begin
      ifu_seen++; last_ifu_rdata = ifu_rdata; last_ifu_err = ifu_resp_err;
      $display("cyc %0d IFU response data=%08h err=%0b", cyc, ifu_rdata, ifu_resp_err);
    end
    if (lsu_resp_valid) begin
      lsu_seen++; last_lsu_rdata = lsu_rdata; last_lsu_err = lsu_resp_err;
      last_lsu_cyc = cyc;
      $display("cyc %0d LSU response data=%08h err=%0b", cyc, lsu_rdata, lsu_resp_err);
    end

    if (hs_i || hs_l) begin
      hs_cyc = cyc;
      grant_bits = {grant_bits[30:0], hs_l};
      grant_n++;
      d = rand_mode ? int'($urandom_range(1, 12)) : resp_delay;
      resp_cd   = (d < 0) ? -1 : d - 1;
      resp_data = rand_mode ? $urandom : fixed_resp_data;
    end

    m_owner = n_owner; m_elapsed = n_elapsed; m_streak = n_streak;

    @(posedge clk);
    #1;
    cyc++;
    if (hs_i) ifu_req_valid = 1'b0;
    if (hs_l) lsu_req_valid = 1'b0;
    if (rand_mode) begin
      if (!ifu_req_valid) begin
        ifu_raddr = $urandom;
        if ($urandom_range(0, 2) == 0) ifu_req_valid = 1'b1;
      end
      if (!lsu_req_valid) begin
        lsu_addr = $urandom; lsu_wdata = $urandom;
        lsu_wmask = 8'($urandom); lsu_wen = 1'($urandom);
        if ($urandom_range(0, 2) == 0) lsu_req_valid = 1'b1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ifu_req_valid = 1; ifu_raddr = 32'h1111_0000;
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h2222_0000;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 8'hff;
    mem_req_ready = 1; mem_resp_valid = 0; mem_rdata = 0;
    @(posedge clk); #1;

    // Reset: requesters pushing, nothing may be granted.
    repeat (2) cycle();
    reset = 1'b0; ifu_req_valid = 0; lsu_req_valid = 0;
    cycle();

    // 1: IFU alone, response two cycles after accept.
    ifu_req_valid = 1; ifu_raddr = 32'h0000_1000;
    resp_delay = 2; fixed_resp_data = 32'h0010_0073; i0 = ifu_seen;
    repeat (5) cycle();
    chk("t1_count", ifu_seen - i0, 1);
    chk("t1_rdata", last_ifu_rdata, 32'h0010_0073);
    chk("t1_err", last_ifu_err, 1'b0);

    // 2: simultaneous IFU and LSU write, LSU first.
    ifu_req_valid = 1; ifu_raddr = 32'h0000_2000;
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h01;
    resp_delay = 1; fixed_resp_data = 32'h0000_0000;
    grant_bits = 0; grant_n = 0;
    repeat (6) cycle();
    chk("t2_grants", grant_n, 2);
    chk("t2_order", grant_bits[1:0], 2'b10);

    // 3: LSU held continuously with IFU waiting.
    grant_bits = 0; grant_n = 0;
    ifu_req_valid = 1; ifu_raddr = 32'h0000_3000;
    for (int k = 0; k < 60 && grant_n < 6; k++) begin
      if (!lsu_req_valid) begin
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h9000_0000 + 32'(k * 4);
      end
      cycle();
    end
    lsu_req_valid = 0;
    chk("t3_grants", grant_n, 6);
    chk("t3_order", grant_bits[5:0], 6'b111101);
    repeat (3) cycle();

    // 4: memory stalls the request for 3 cycles.
    mem_req_ready = 0; ifu_req_valid = 1; ifu_raddr = 32'h0000_4000;
    i0 = ifu_seen; grant_n = 0;
    repeat (3) cycle();
    chk("t4_no_grant", grant_n, 0);
    mem_req_ready = 1; resp_delay = 1;
    repeat (3) cycle();
    chk("t4_count", ifu_seen - i0, 1);

    // 5: LSU read times out, late response ignored, IFU then works.
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h0000_5000;
    resp_delay = 10; l0 = lsu_seen; i0 = ifu_seen;
    repeat (12) cycle();
    chk("t5_count", lsu_seen - l0, 1);
    chk("t5_latency", last_lsu_cyc - hs_cyc, TIMEOUT);
    chk("t5_err", last_lsu_err, 1'b1);
    chk("t5_rdata", last_lsu_rdata, 32'd0);
    chk("t5_no_ifu", ifu_seen - i0, 0);
    ifu_req_valid = 1; ifu_raddr = 32'h0000_5100; resp_delay = 2;
    fixed_resp_data = 32'hCAFE_0001;
    repeat (5) cycle();
    chk("t5_ifu_count", ifu_seen - i0, 1);
    chk("t5_ifu_data", {last_ifu_err, last_ifu_rdata}, {1'b0, 32'hCAFE_0001});

    // 6: reset during WAIT_IFU, memory answers afterwards.
    ifu_req_valid = 1; ifu_raddr = 32'h0000_6000; resp_delay = 4; i0 = ifu_seen;
    cycle();
    cycle();
    reset = 1; cycle();
    reset = 0;
    repeat (4) cycle();
    chk("t6_no_resp", ifu_seen - i0, 0);
    ifu_req_valid = 1; ifu_raddr = 32'h0000_6100; resp_delay = 2;
    fixed_resp_data = 32'h0BAD_F00D;
    repeat (5) cycle();
    chk("t6_after", ifu_seen - i0, 1);
    chk("t6_data", last_ifu_rdata, 32'h0BAD_F00D);

    // Random traffic against the model.
    rand_mode = 1;
    repeat (3000) cycle();
    rand_mode = 0; reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
